// File: rtl/l2_port_arbiter_pkg.sv
// Shared types for the L1-to-L2 port arbiter: cache operations, arbiter FSM states
// and the rule deciding which operations actually reach the next level.
package l2_port_arbiter_pkg;

    typedef enum logic [1:0] {
        NOP        = 2'd0,
        READ_OUT   = 2'd1,
        WRITE_OUT  = 2'd2,
        INVALIDATE = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } arb_state_t;

    // Operation that is granted and acknowledged without a next-level access.
    localparam op_t LOCAL_ONLY_OP = NOP;

    function automatic logic needs_next_level(input op_t op);
        return op != LOCAL_ONLY_OP;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above rr_ptr, wrapping at NREQ.
// Purely combinational.
module l2_port_arbiter_rr_picker
    import l2_port_arbiter_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
)(
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   index
);

    logic [IW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] rot_valid;

    // Candidate gi is the requester gi positions after rr_ptr, modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [IW:0] sum;
        assign sum           = {1'b0, rr_ptr} + (IW+1)'(gi);
        assign cand_idx[gi]  = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
        assign rot_valid[gi] = req_valid[cand_idx[gi]];
    end

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                found = 1'b1;
                index = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single next-level cache port between NREQ L1 caches with round-robin
// grants, one outstanding transaction and a response watchdog.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter  int NREQ     = 2,
    parameter  int ADDRBITS = 32,
    parameter  int DATABITS = 32,
    parameter  int TIMEOUT  = 1023,
    localparam int IW       = $clog2(NREQ),
    localparam int WW       = $clog2(TIMEOUT + 1)
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  op_t                 req_op    [NREQ],
    input  logic [ADDRBITS-1:0] req_addr  [NREQ],
    input  logic [DATABITS-1:0] req_wdata [NREQ],
    output logic [NREQ-1:0]     req_ack,
    output logic [DATABITS-1:0] req_rdata,
    output logic                nl_valid,
    output op_t                 nl_op,
    output logic [ADDRBITS-1:0] nl_addr,
    output logic [DATABITS-1:0] nl_wdata,
    input  logic                nl_ack,
    input  logic [DATABITS-1:0] nl_rdata,
    output logic [IW-1:0]       grant_id,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);
    localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

    arb_state_t          state_reg, state_next;
    logic [IW-1:0]       rr_ptr_reg;
    logic [IW-1:0]       grant_id_reg;
    op_t                 nl_op_reg;
    logic [ADDRBITS-1:0] nl_addr_reg;
    logic [DATABITS-1:0] nl_wdata_reg;
    logic [DATABITS-1:0] req_rdata_reg;
    logic [WW-1:0]       watchdog_reg;
    logic                timeout_err_reg;

    logic                pick_found;
    logic [IW-1:0]       pick_index;
    logic                wd_expired;

    l2_port_arbiter_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .found     (pick_found),
        .index     (pick_index)
    );

    assign wd_expired = (watchdog_reg == WD_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A late ack still wins over a watchdog expiring in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_found) state_next = ISSUE;
            ISSUE:   state_next = needs_next_level(nl_op_reg) ? WAIT : RESPOND;
            WAIT:    if (nl_ack || wd_expired) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        nl_valid = 1'b0;
        req_ack  = '0;
        busy     = (state_reg != IDLE);
        case (state_reg)
            ISSUE:   nl_valid = needs_next_level(nl_op_reg);
            RESPOND: req_ack[grant_id_reg] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            nl_op_reg       <= NOP;
            nl_addr_reg     <= '0;
            nl_wdata_reg    <= '0;
            req_rdata_reg   <= '0;
            watchdog_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_id_reg <= pick_index;
                        nl_op_reg    <= req_op[pick_index];
                        nl_addr_reg  <= req_addr[pick_index];
                        nl_wdata_reg <= req_wdata[pick_index];
                    end
                end
                WAIT: begin
                    // On expiry the requester gets zero data rather than a hang.
                    if (nl_ack) begin
                        req_rdata_reg <= nl_rdata;
                    end else if (wd_expired) begin
                        req_rdata_reg   <= '0;
                        timeout_err_reg <= 1'b1;
                    end
                    if (!wd_expired) begin
                        watchdog_reg <= watchdog_reg + 1'b1;
                    end
                end
                RESPOND: begin
                    rr_ptr_reg   <= (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + 1'b1;
                    watchdog_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign req_rdata   = req_rdata_reg;
    assign nl_op       = nl_op_reg;
    assign nl_addr     = nl_addr_reg;
    assign nl_wdata    = nl_wdata_reg;
    assign grant_id    = grant_id_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Shares the single next-level (L2) cacheinterface port between NREQ first-level caches (I-cache is requester 0, D-cache is requester 1).
- Fair round-robin arbitration.
- One outstanding next-level transaction at a time.
- Each requester sees a simple req/ack handshake.
- Watchdog flags a next-level response that never arrives.
- Sits between the L1 cache instances and the L2 cache in the top-level cache hierarchy.

Parameters:
NREQ, 2, number of requesting caches (2..8)
ADDRBITS, 32, address width
DATABITS, 32, word width of read/write data
TIMEOUT, 1023, max cycles to wait for next-level ack before error

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request strobe, held until ack
req_op  in  NREQ x op_t  per-requester operation (READ_OUT, WRITE_OUT, INVALIDATE, NOP)
req_addr  in  NREQ x ADDRBITS  per-requester address
req_wdata  in  NREQ x DATABITS  per-requester write data
req_ack  out  NREQ  one-cycle completion pulse to the granted requester
req_rdata  out  DATABITS  read data, valid when req_ack asserted
nl_valid  out  1  next-level request strobe
nl_op  out  op_t  next-level operation
nl_addr  out  ADDRBITS  next-level address
nl_wdata  out  DATABITS  next-level write data
nl_ack  in  1  next-level completion pulse
nl_rdata  in  DATABITS  next-level read data, valid with nl_ack
grant_id  out  $clog2(NREQ)  index of current/last granted requester
busy  out  1  transaction in flight
timeout_err  out  1  sticky error, set on watchdog expiry

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, timeout_err=0.
  - nl_valid=0, nl_op=NOP, nl_addr=0, nl_wdata=0.
  - req_ack=0, req_rdata=0, watchdog=0.
- State machine arb_state_t:
  - IDLE: if any req_valid, go to ISSUE. Pick the first asserted index searching upward from rr_ptr, wrapping at NREQ. Latch op/addr/wdata and grant_id at this edge. busy=1 from the next cycle.
  - ISSUE: nl_valid=1 with latched fields (exactly 1 cycle). Go to WAIT.
  - WAIT: nl_valid=0; watchdog increments each cycle.
    - On nl_ack: latch nl_rdata into req_rdata and go to RESPOND.
    - If watchdog==TIMEOUT and no nl_ack: set timeout_err and go to RESPOND with req_rdata=0, so the requester is not deadlocked.
  - RESPOND: req_ack[grant_id]=1 for exactly one cycle. rr_ptr=(grant_id+1) mod NREQ. Clear watchdog and busy. Go to IDLE.
- Latency: req_valid sampled at edge N → nl_valid high during cycle N+1 → nl_ack at cycle M → req_ack high during cycle M+1. Minimum request-to-ack is 3 cycles.
- Back-to-back requests: earliest re-grant decision is the edge after RESPOND (no combinational IDLE bypass).
- NOP ops: still granted and acked. nl_valid stays 0 and WAIT is skipped (ISSUE→RESPOND) for them.
- Fairness: a requester holding req_valid is granted within NREQ transactions.
- Requester drops req_valid while granted: the transaction still completes and the ack is still pulsed; the requester must ignore it.
- nl_ack outside WAIT: ignored.
- nl_ack in the same cycle as watchdog reaching TIMEOUT: the ack wins, no error.
- Reset mid-transaction: the FSM returns to IDLE next edge and no ack is issued. The next level is expected to be reset by the same reset.
- timeout_err: cleared only by reset.
- watchdog width: $clog2(TIMEOUT+1); saturates, never wraps.

Decomposition:
- Shared cachepkg:
  - op_t: reuse existing, add WRITE_OUT if absent.
  - arb_state_t {IDLE, ISSUE, WAIT, RESPOND}.
  - Constant for NOP handling.
- Natural sub-module: rr_picker. Purely combinational; inputs req_valid and rr_ptr; outputs found and index. Tested standalone.

Test Plan:
- Single read: req_valid=01, req_addr[0]=0x0000_1040, nl_ack 2 cycles after nl_valid with rdata 0xDEADBEEF → nl_addr=0x0000_1040, req_ack=01 with req_rdata=0xDEADBEEF, 4 cycles after the request edge.
- Contention: req_valid=11 held continuously, rr_ptr=0 → grant order 0,1,0,1 over 4 transactions, each req_ack a single-cycle pulse.
- Timeout: TIMEOUT=15, no nl_ack → req_ack to the granted requester 16 cycles into WAIT with rdata=0. timeout_err=1 and stays set until reset.
- Ack/timeout collision: nl_ack in the same cycle the watchdog reaches TIMEOUT → timeout_err=0 and rdata taken from nl_rdata.
- Reset mid-WAIT: reset asserted 2 cycles into WAIT → next cycle busy=0, nl_valid=0, no req_ack ever pulsed, grant_id=0.
- NOP request: req_op[1]=NOP → nl_valid never asserted, req_ack=10 two cycles after the request edge.
